// File: rtl/vedic_mult_pipe.sv
// Pipelined NxN Urdhva-Tiryagbhyam multiplier built from 4x4 Vedic cells.
// Three stages: sign/magnitude, crosswise column sums, carry-propagate and sign.
module vedic_mult_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int ND   = WIDTH / 4;
    localparam int NCOL = 2 * ND - 1;
    localparam int CW   = 8 + $clog2(ND);
    localparam int PW   = 2 * WIDTH;

    if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("vedic_mult_pipe: WIDTH must be a power of two >= 4");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("vedic_mult_pipe: TAG_W must be >= 1");
    end

    // Most negative operand maps to 2^(WIDTH-1), still representable unsigned.
    function automatic logic [WIDTH-1:0] to_mag(input logic signed [WIDTH-1:0] v,
                                                input logic s);
        return (s && v[WIDTH-1]) ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] m, input logic neg);
        return neg ? (~m + 1'b1) : m;
    endfunction

    function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] r;
        logic [2:0] s;
        r = '0;
        for (int k = 0; k < 7; k++) begin
            s = '0;
            for (int i = 0; i < 4; i++) begin
                if (k - i >= 0 && k - i <= 3) s = s + 3'(x[i] & y[k-i]);
            end
            r = r + (8'(s) << k);
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] carry_prop(input logic [NCOL-1:0][CW-1:0] c);
        logic [PW-1:0] acc;
        acc = '0;
        for (int k = 0; k < NCOL; k++) acc = acc + (PW'(c[k]) << (4 * k));
        return acc;
    endfunction

    logic                       en;
    logic                       vld_p0, vld_p1;
    logic [WIDTH-1:0]           a_mag_p0, b_mag_p0;
    logic                       neg_p0, neg_p1;
    logic [TAG_W-1:0]           tag_p0, tag_p1;
    logic [NCOL-1:0][CW-1:0]    col_c, col_p1;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        col_c = '0;
        for (int i = 0; i < ND; i++) begin
            for (int j = 0; j < ND; j++) begin
                col_c[i+j] = col_c[i+j] + CW'(vedic4(a_mag_p0[4*i +: 4], b_mag_p0[4*j +: 4]));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
            out_p     <= '0;
            out_tag   <= '0;
        end else if (en) begin
            vld_p0    <= in_valid;
            vld_p1    <= vld_p0;
            out_valid <= vld_p1;
            // stage 3: carry-propagate add, then restore sign
            if (vld_p1) begin
                out_p   <= apply_sign(carry_prop(col_p1), neg_p1);
                out_tag <= tag_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // stage 1: operand magnitudes and product sign
        if (en && in_valid) begin
            a_mag_p0 <= to_mag(in_a, in_signed);
            b_mag_p0 <= to_mag(in_b, in_signed);
            neg_p0   <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            tag_p0   <= in_tag;
        end
        // stage 2: crosswise column sums, carries left unresolved
        if (en && vld_p0) begin
            col_p1 <= col_c;
            neg_p1 <= neg_p0;
            tag_p1 <= tag_p0;
        end
    end

endmodule
